// File: rtl/out_chain_node_if.sv
// Word handshake between output-chain nodes (and from a local port into a node).
// The master drives data/valid; the slave answers with ready (the accept strobe).
interface out_chain_node_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/out_chain_node.sv
// Output-chain node: FWFT FIFO fed by upstream and local sources, drained downstream.
// Define OUT_CHAIN_FAIR_EN to bound local starvation to MAX_UP consecutive upstream grants.
module out_chain_node #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned MAX_UP = 4
) (
  input  logic                       clock,
  input  logic                       sclr,
  out_chain_node_if.slave            up,
  out_chain_node_if.slave            loc,
  out_chain_node_if.master           dn,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (MAX_UP < 1 || MAX_UP > 255) begin : g_bad_max_up
    $error("MAX_UP must be in 1..255");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_open;
  logic              w_loc_pri;
  logic              w_up_gnt;
  logic              w_loc_gnt;
  logic              w_wr;
  logic              w_rd;
  logic [DATA_W-1:0] w_wdata;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_open  = !sclr && !w_full;

`ifdef OUT_CHAIN_FAIR_EN
  localparam int unsigned SW = $clog2(MAX_UP+1);
  logic [SW-1:0] r_streak;

  assign w_loc_pri = (r_streak == SW'(MAX_UP));

  // Streak only grows on upstream grants made while local waits, so it never passes MAX_UP.
  always_ff @(posedge clock) begin
    if (sclr || !loc.valid || w_loc_gnt) begin
      r_streak <= '0;
    end else if (w_up_gnt) begin
      r_streak <= r_streak + SW'(1);
    end
  end
`else
  assign w_loc_pri = 1'b0;
`endif

  assign w_up_gnt  = w_open && up.valid  && !(loc.valid && w_loc_pri);
  assign w_loc_gnt = w_open && loc.valid && (!up.valid || w_loc_pri);
  assign w_wr      = w_up_gnt || w_loc_gnt;
  assign w_rd      = !sclr && !w_empty && dn.ready;
  assign w_wdata   = w_loc_gnt ? loc.data : up.data;

  assign up.ready  = w_up_gnt;
  assign loc.ready = w_loc_gnt;

  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dn.data  = r_mem[r_rd_ptr];
  assign dn.valid = !w_empty;
  assign count    = r_count;
  assign full     = w_full;
  assign empty    = w_empty;
endmodule

// File: tb/tb_out_chain_node.sv
// Randomized bench for out_chain_node against a queue-based reference, plus an 8-node chain.
module tb_out_chain_node;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEP   = 16;
  localparam int unsigned MAXU  = 4;
  localparam int unsigned NODES = 8;
  localparam int unsigned NWORD = 6;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- single node under test ----------------
  logic          t_rst = 1'b1;
  logic          t_uv  = 1'b0;
  logic [DW-1:0] t_ud  = '0;
  logic          t_lv  = 1'b0;
  logic [DW-1:0] t_ld  = '0;
  logic          t_dr  = 1'b0;
  logic [4:0]    d_count;
  logic          d_full;
  logic          d_empty;

  out_chain_node_if #(.DATA_W(DW)) up_if ();
  out_chain_node_if #(.DATA_W(DW)) loc_if ();
  out_chain_node_if #(.DATA_W(DW)) dn_if ();

  assign up_if.data   = t_ud;
  assign up_if.valid  = t_uv;
  assign loc_if.data  = t_ld;
  assign loc_if.valid = t_lv;
  assign dn_if.ready  = t_dr;

  out_chain_node #(.DATA_W(DW), .DEPTH(DEP), .MAX_UP(MAXU)) u_dut (
    .clock (clock),
    .sclr  (t_rst),
    .up    (up_if),
    .loc   (loc_if),
    .dn    (dn_if),
    .count (d_count),
    .full  (d_full),
    .empty (d_empty)
  );

  // Reference: FIFO contents as a queue, plus upstream grants seen while local waits.
  logic [DW-1:0] mq[$];
  int unsigned   m_ups_while_loc = 0;

  logic          g_up, g_loc, g_pop, ex_up, ex_loc;
  logic [DW-1:0] g_pop_data;

  task automatic step();
    logic ex_full;
    #1;
    ex_full = (mq.size() == DEP);
    ex_up   = 1'b0;
    ex_loc  = 1'b0;
    if (!t_rst && !ex_full) begin
      if (t_uv && t_lv) begin
`ifdef OUT_CHAIN_FAIR_EN
        if (m_ups_while_loc == MAXU) ex_loc = 1'b1;
        else                         ex_up  = 1'b1;
`else
        ex_up = 1'b1;
`endif
      end else begin
        ex_up  = t_uv;
        ex_loc = t_lv;
      end
    end
    chk("up_ready", 32'(up_if.ready), 32'(ex_up));
    chk("loc_ack", 32'(loc_if.ready), 32'(ex_loc));
    chk("dn_valid", 32'(dn_if.valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("dn_data", 32'(dn_if.data), 32'(mq[0]));
    chk("count", 32'(d_count), 32'(mq.size()));
    chk("full", 32'(d_full), 32'(mq.size() == DEP));
    chk("empty", 32'(d_empty), 32'(mq.size() == 0));
    g_up       = up_if.ready;
    g_loc      = loc_if.ready;
    g_pop      = dn_if.valid && t_dr;
    g_pop_data = dn_if.data;
    @(posedge clock);
    if (t_rst) begin
      mq.delete();
      m_ups_while_loc = 0;
    end else begin
      if (t_dr && mq.size() != 0) void'(mq.pop_front());
      if (ex_up)  mq.push_back(t_ud);
      if (ex_loc) mq.push_back(t_ld);
      if (!t_lv || ex_loc) m_ups_while_loc = 0;
      else if (ex_up)      m_ups_while_loc++;
    end
    #1;
  endtask

  // Sources keep a word until it is accepted, then may present a fresh one.
  task automatic next_sources(input int unsigned pct_valid);
    if (!(t_uv && !g_up)) begin
      t_uv = ($urandom_range(99) < pct_valid);
      t_ud = DW'($urandom);
    end
    if (!(t_lv && !g_loc)) begin
      t_lv = ($urandom_range(99) < pct_valid);
      t_ld = DW'($urandom);
    end
  endtask

  // ---------------- 8-node chain ----------------
  logic          c_rst = 1'b1;
  logic [NODES-1:0] c_lv = '0;
  logic [DW-1:0] c_ld [NODES];
  logic [NODES-1:0] c_ack;
  logic [NODES-1:0] c_empty;
  logic [NODES-1:0] c_full;
  logic [4:0]    c_cnt [NODES];
  logic          s_valid;
  logic [DW-1:0] s_data;

  out_chain_node_if #(.DATA_W(DW)) c_lnk [NODES+1] ();
  out_chain_node_if #(.DATA_W(DW)) c_loc [NODES] ();

  assign c_lnk[0].valid     = 1'b0;
  assign c_lnk[0].data      = '0;
  assign c_lnk[NODES].ready = 1'b1;
  assign s_valid            = c_lnk[NODES].valid;
  assign s_data             = c_lnk[NODES].data;

  for (genvar k = 0; k < NODES; k++) begin : g_chain
    assign c_loc[k].valid = c_lv[k];
    assign c_loc[k].data  = c_ld[k];
    assign c_ack[k]       = c_loc[k].ready;
    out_chain_node #(.DATA_W(DW), .DEPTH(DEP), .MAX_UP(MAXU)) u_node (
      .clock (clock),
      .sclr  (c_rst),
      .up    (c_lnk[k]),
      .loc   (c_loc[k]),
      .dn    (c_lnk[k+1]),
      .count (c_cnt[k]),
      .full  (c_full[k]),
      .empty (c_empty[k])
    );
  end

  initial begin
    int unsigned n_up, n_loc, n_pop, wait_gnt, got;
    int unsigned c_seq [NODES];
    int unsigned exp_seq [NODES];
    logic [DW-1:0] w;
    bit done;

    for (int unsigned k = 0; k < NODES; k++) c_ld[k] = '0;
    g_up = 1'b0; g_loc = 1'b0;
    @(posedge clock); #1;

    // Reset held with both sources valid: nothing granted, FIFO idle.
    t_rst = 1'b1; t_uv = 1'b1; t_lv = 1'b1; t_ud = 8'hA5; t_ld = 8'h5A; t_dr = 1'b1;
    for (int unsigned i = 0; i < 3; i++) step();
    t_rst = 1'b0;
    step();
    chk("first_grant_up", 32'(g_up), 32'd1);

    // Fill from local with downstream stalled, then drain in order across the wrap.
    t_rst = 1'b1; t_uv = 1'b0; t_lv = 1'b0; t_dr = 1'b0;
    step();
    t_rst = 1'b0;
    w = '0;
    for (int unsigned i = 0; i < 22; i++) begin
      t_lv = (w < 8'h14);
      t_ld = w;
      step();
      if (g_loc) w++;
    end
    chk("fill_accepted", 32'(w), 32'd16);
    chk("fill_full", 32'(d_full), 32'd1);
    t_dr  = 1'b1;
    n_pop = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      t_lv = (w < 8'h14);
      t_ld = w;
      step();
      if (g_loc) w++;
      if (g_pop) begin
        chk("fill_order", 32'(g_pop_data), n_pop);
        n_pop++;
      end
    end
    chk("fill_drained", n_pop, 32'd20);

    // Full with read and upstream write in the same cycle: write waits a cycle.
    t_dr = 1'b0; t_lv = 1'b0; t_uv = 1'b1;
    for (int unsigned i = 0; i < 18; i++) begin
      t_ud = DW'(i);
      step();
    end
    t_dr = 1'b1; t_ud = 8'hEE;
    step();
    chk("full_refuse", 32'(g_up), 32'd0);
    chk("count_15", 32'(d_count), 32'd15);
    t_dr = 1'b0;
    step();
    chk("next_accept", 32'(g_up), 32'd1);
    chk("count_16", 32'(d_count), 32'd16);

    // Both sources continuously valid for 40 cycles from an empty FIFO.
    t_rst = 1'b1; step(); t_rst = 1'b0;
    t_uv = 1'b1; t_lv = 1'b1; t_dr = 1'b1;
    n_up = 0; n_loc = 0; wait_gnt = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      step();
      if (g_up)  n_up++;
      if (g_loc) n_loc++;
      if (g_up || g_loc) wait_gnt++;
      if (g_loc) begin
        chk("loc_wait_bound", 32'(wait_gnt <= MAXU + 1), 32'd1);
        wait_gnt = 0;
      end
      t_ud = DW'($urandom);
      if (g_loc) t_ld = DW'($urandom);
    end
`ifdef OUT_CHAIN_FAIR_EN
    chk("up_words", n_up, 32'd32);
    chk("loc_words", n_loc, 32'd8);
`else
    chk("up_words", n_up, 32'd40);
    chk("loc_words", n_loc, 32'd0);
`endif

    // Random traffic with occasional reset.
    for (int unsigned i = 0; i < 3000; i++) begin
      t_rst = ($urandom_range(199) == 0);
      t_dr  = ($urandom_range(99) < ((i / 500) % 2 == 0 ? 70 : 30));
      next_sources(60);
      step();
    end
    t_rst = 1'b0; t_uv = 1'b0; t_lv = 1'b0; t_dr = 1'b1;
    for (int unsigned i = 0; i < 20; i++) step();
    chk("rand_empty", 32'(d_empty), 32'd1);

    // Chain: each node injects NWORD words tagged with its index.
    for (int unsigned k = 0; k < NODES; k++) begin
      c_seq[k] = 0; exp_seq[k] = 0;
      c_ld[k]  = DW'(k << 5);
    end
    c_rst = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    c_rst = 1'b0;
    c_lv  = '1;
    got   = 0;
    done  = 1'b0;
    for (int unsigned cyc = 0; cyc < 1000 && !done; cyc++) begin
      logic [NODES-1:0] ack;
      #1;
      ack = c_ack & c_lv;
      if (s_valid) begin
        chk("chain_order", 32'(s_data[4:0]), exp_seq[s_data[7:5]]);
        exp_seq[s_data[7:5]]++;
        got++;
      end
      @(posedge clock); #1;
      for (int unsigned k = 0; k < NODES; k++) begin
        if (ack[k]) begin
          c_seq[k]++;
          if (c_seq[k] == NWORD) c_lv[k] = 1'b0;
          else c_ld[k] = DW'((k << 5) | c_seq[k]);
        end
      end
      done = (got == NODES * NWORD) && (c_empty == '1);
    end
    chk("chain_done", 32'(done), 32'd1);
    chk("chain_total", got, NODES * NWORD);
    for (int unsigned k = 0; k < NODES; k++) chk("chain_per_src", exp_seq[k], NWORD);
    chk("chain_empty", 32'(c_empty), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
